gene_xover_mutate_pipe: RTL and testbench
=========================================

Name: gene_xover_mutate_pipe

Overview:
- Pipelined, parametrised crossover-plus-mutation engine for NEAT genomes.
- Takes one homologous gene pair per beat (parent A/B attribute vectors) and applies per-attribute crossover selection.
- Then applies per-attribute mutation with type-dependent value masking.
- Emits the child gene over a valid/ready stream. Sits between the genome memory reader and the child genome writer; random bytes come from the shared random-number block.

Parameters:
- ATTR_W, 8, width of one attribute (fixed point, MSB=2^0, LSB=2^-(ATTR_W-1))
- NUM_ATTR, 3, attributes per gene
- XOVER_THRESH, 8'h40, crossover threshold (0.5 in the fixed-point format)
- NODE_MASK, {8'h07,8'h0F,8'hFF}, packed per-attribute mutation mask for node genes (attr NUM_ATTR-1 in MSBs)
- CONN_MASK, {8'h00,8'h00,8'h01}, packed per-attribute mutation mask for conn genes
- CNT_W, 16, width of the mutation statistics counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- gene_a  in  NUM_ATTR*ATTR_W  parent A attributes
- gene_b  in  NUM_ATTR*ATTR_W  parent B attributes
- gene_type  in  1  0=node, 1=conn
- bias  in  1  fitter parent: 0=A, 1=B
- rand_xover  in  NUM_ATTR*ATTR_W  crossover random, one byte per attribute
- rand_msel  in  NUM_ATTR*ATTR_W  mutation-select random
- rand_mval  in  NUM_ATTR*ATTR_W  mutation-value random
- mutation_prob  in  ATTR_W  mutation probability, same fixed-point format
- out_valid  out  1  child beat valid
- out_ready  in  1  downstream accepts
- child  out  NUM_ATTR*ATTR_W  child attributes
- child_type  out  1  gene_type passed through
- mut_flags  out  NUM_ATTR  attribute i was mutated
- stat_clr  in  1  clear mut_count
- mut_count  out  CNT_W  total mutated attributes, saturating

Behaviour:
- All inputs, including the random buses, are sampled only on an accepted input beat.
- Stage 1 (crossover), per attribute i:
  - pick = bias when rand_xover[i] <= XOVER_THRESH; otherwise pick = ~bias. The comparison is unsigned.
  - pick=0 takes gene_a[i]; pick=1 takes gene_b[i].
  - Registered into s1 along with gene_type, rand_msel, rand_mval and mutation_prob.
- Stage 2 (mutation), per attribute i:
  - mutate[i] = (rand_msel[i] <= mutation_prob), unsigned.
  - Mutated value = rand_mval[i] & (gene_type ? CONN_MASK[i] : NODE_MASK[i]); otherwise the stage-1 value.
  - Registered into output regs child, child_type and mut_flags.
- Latency: exactly 2 cycles from input accept to out_valid when there is no backpressure.
- Handshake:
  - Each stage holds a valid bit. A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational. There is no skid buffer.
  - Throughput is one beat per cycle while out_ready=1.
  - While out_valid && !out_ready, child, child_type and mut_flags are held stable.
- mut_count:
  - Increments by popcount(mut_flags) on each output handshake (out_valid && out_ready).
  - Saturates at 2^CNT_W-1.
  - stat_clr zeroes it. If stat_clr and a handshake coincide, the result is popcount(mut_flags) (clear, then add).
- Reset: all valid bits = 0; out_valid=0, child=0, child_type=0, mut_flags=0, mut_count=0. in_ready goes to 1 in the cycle after reset deasserts.
  - Reset mid-stream drops in-flight beats silently.
  - in_ready=0 while reset is high.
- Boundaries:
  - mutation_prob=8'hFF mutates every attribute.
  - mutation_prob=0 mutates only when rand_msel=0.
  - A CONN_MASK of 0 forces reserved attributes to 0 whenever they mutate.

Decomposition:
- Package neat_ga_pkg holds:
  - ATTR_W default
  - gene-type constants GENE_NODE=1'b0 and GENE_CONN=1'b1
  - FX_HALF=8'h40
  - default NODE_MASK/CONN_MASK
  - attribute index constants ATTR_RESP_EN=0, ATTR_ACT=1, ATTR_AGG=2
- One sub-module, gene_attr_lane: combinational crossover pick plus mutate/mask for a single attribute, instantiated NUM_ATTR times with a generate loop. All pipeline registers and the counter stay in the top level.

Test Plan:
- Node gene, gene_a={03,05,10}, gene_b={07,0A,20}, bias=0, rand_xover all 8'h40, rand_msel all FF, prob=8'h10 -> 2 cycles later child={03,05,10}, mut_flags=0.
- Same beat with rand_xover[0]=8'h41 -> child attr0=8'h20, other attributes from A.
- Conn gene, prob=8'hFF, rand_mval all 8'hFF -> child={00,00,01}, mut_flags=3'b111, mut_count=3 after handshake.
- Node gene, rand_msel={00,FF,00}, prob=0, rand_mval={FF,FF,FF} -> child attr2=07, attr0=FF, attr1 from crossover; mut_flags=3'b101.
- Stream 4 beats with out_ready low for cycles 2-5 -> in_ready drops once both stages are full, outputs are held stable, and all 4 beats emerge in order with none lost or duplicated.
- Preload mut_count near 2^CNT_W-1 with CNT_W=4 override and keep mutating -> saturates at 15; stat_clr during a 2-flag handshake -> 2. Assert reset with 2 beats in flight -> out_valid=0 next cycle and nothing emerges.

Source files
------------

// File: rtl/gene_xover_mutate_pipe_pkg.sv
// Shared NEAT GA constants: fixed-point format, gene types, default mutation masks.
// Attribute slots are packed with attribute 0 in the LSBs.
package neat_ga_pkg;
  localparam int DEF_ATTR_W   = 8;
  localparam int DEF_NUM_ATTR = 3;

  localparam logic GENE_NODE = 1'b0;
  localparam logic GENE_CONN = 1'b1;

  // 0.5 with MSB = 2^0 and LSB = 2^-(ATTR_W-1)
  localparam logic [7:0] FX_HALF = 8'h40;

  localparam logic [23:0] DEF_NODE_MASK = {8'h07, 8'h0F, 8'hFF};
  localparam logic [23:0] DEF_CONN_MASK = {8'h00, 8'h00, 8'h01};

  localparam int ATTR_RESP_EN = 0;
  localparam int ATTR_ACT     = 1;
  localparam int ATTR_AGG     = 2;
endpackage

// File: rtl/gene_xover_mutate_pipe_if.sv
// Gene-pair input stream and child-gene output stream of the crossover/mutation pipe.
// master = environment side (reader + writer), slave = pipe side.
interface gene_xover_mutate_pipe_if #(
  parameter int ATTR_W   = 8,
  parameter int NUM_ATTR = 3
);
  localparam int VEC_W = NUM_ATTR * ATTR_W;

  logic                in_valid;
  logic                in_ready;
  logic [VEC_W-1:0]    gene_a;
  logic [VEC_W-1:0]    gene_b;
  logic                gene_type;
  logic                bias;
  logic [VEC_W-1:0]    rand_xover;
  logic [VEC_W-1:0]    rand_msel;
  logic [VEC_W-1:0]    rand_mval;
  logic [ATTR_W-1:0]   mutation_prob;

  logic                out_valid;
  logic                out_ready;
  logic [VEC_W-1:0]    child;
  logic                child_type;
  logic [NUM_ATTR-1:0] mut_flags;

  modport master (
    output in_valid, gene_a, gene_b, gene_type, bias,
    output rand_xover, rand_msel, rand_mval, mutation_prob,
    input  in_ready,
    input  out_valid, child, child_type, mut_flags,
    output out_ready
  );

  modport slave (
    input  in_valid, gene_a, gene_b, gene_type, bias,
    input  rand_xover, rand_msel, rand_mval, mutation_prob,
    output in_ready,
    output out_valid, child, child_type, mut_flags,
    input  out_ready
  );
endinterface

// File: rtl/gene_xover_mutate_pipe_lane.sv
// One attribute lane: crossover pick (stage 1 path) and mutate/mask (stage 2 path).
// Purely combinational; the two paths are fed from different pipeline stages.
module gene_attr_lane
  import neat_ga_pkg::*;
#(
  parameter int                ATTR_W       = DEF_ATTR_W,
  parameter logic [ATTR_W-1:0] XOVER_THRESH = FX_HALF,
  parameter logic [ATTR_W-1:0] NODE_MASK    = '1,
  parameter logic [ATTR_W-1:0] CONN_MASK    = '0
) (
  input  logic [ATTR_W-1:0] attr_a,
  input  logic [ATTR_W-1:0] attr_b,
  input  logic              bias,
  input  logic [ATTR_W-1:0] rand_xover,
  output logic [ATTR_W-1:0] xover_val,
  input  logic [ATTR_W-1:0] attr_xo,
  input  logic              gene_type,
  input  logic [ATTR_W-1:0] rand_msel,
  input  logic [ATTR_W-1:0] rand_mval,
  input  logic [ATTR_W-1:0] mutation_prob,
  output logic [ATTR_W-1:0] mut_val,
  output logic              mut_flag
);
  logic              pick;
  logic [ATTR_W-1:0] mask;

  always_comb begin
    // Low random draw inherits from the fitter parent
    pick      = (rand_xover <= XOVER_THRESH) ? bias : ~bias;
    xover_val = pick ? attr_b : attr_a;
    mask      = (gene_type == GENE_CONN) ? CONN_MASK : NODE_MASK;
    mut_flag  = (rand_msel <= mutation_prob);
    mut_val   = mut_flag ? (rand_mval & mask) : attr_xo;
  end
endmodule

// File: rtl/gene_xover_mutate_pipe.sv
// Two-stage NEAT gene crossover + mutation pipe with valid/ready streams
// and a saturating count of mutated attributes.
module gene_xover_mutate_pipe
  import neat_ga_pkg::*;
#(
  parameter int                           ATTR_W       = DEF_ATTR_W,
  parameter int                           NUM_ATTR     = DEF_NUM_ATTR,
  parameter logic [ATTR_W-1:0]            XOVER_THRESH = FX_HALF,
  parameter logic [NUM_ATTR*ATTR_W-1:0]   NODE_MASK    = DEF_NODE_MASK,
  parameter logic [NUM_ATTR*ATTR_W-1:0]   CONN_MASK    = DEF_CONN_MASK,
  parameter int                           CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  gene_xover_mutate_pipe_if.slave      bus,
  input  logic                         stat_clr,
  output logic [CNT_W-1:0]             mut_count
);
  localparam int VEC_W = NUM_ATTR * ATTR_W;

  logic                vld_p1;
  logic [VEC_W-1:0]    xo_p1;
  logic                type_p1;
  logic [VEC_W-1:0]    msel_p1;
  logic [VEC_W-1:0]    mval_p1;
  logic [ATTR_W-1:0]   prob_p1;

  logic                vld_p2;
  logic [VEC_W-1:0]    child_p2;
  logic                type_p2;
  logic [NUM_ATTR-1:0] flags_p2;

  logic [VEC_W-1:0]    xo_val;
  logic [VEC_W-1:0]    mut_val;
  logic [NUM_ATTR-1:0] mut_flag;

  logic adv_p1, adv_p2, accept, out_hs;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ATTR-1:0] f);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_ATTR; i++) n = n + {{(CNT_W-1){1'b0}}, f[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, base} + {1'b0, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign bus.in_ready = !reset && adv_p1;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = vld_p2 && bus.out_ready;

  for (genvar i = 0; i < NUM_ATTR; i++) begin : g_lane
    gene_attr_lane #(
      .ATTR_W       (ATTR_W),
      .XOVER_THRESH (XOVER_THRESH),
      .NODE_MASK    (NODE_MASK[i*ATTR_W +: ATTR_W]),
      .CONN_MASK    (CONN_MASK[i*ATTR_W +: ATTR_W])
    ) u_lane (
      .attr_a        (bus.gene_a[i*ATTR_W +: ATTR_W]),
      .attr_b        (bus.gene_b[i*ATTR_W +: ATTR_W]),
      .bias          (bus.bias),
      .rand_xover    (bus.rand_xover[i*ATTR_W +: ATTR_W]),
      .xover_val     (xo_val[i*ATTR_W +: ATTR_W]),
      .attr_xo       (xo_p1[i*ATTR_W +: ATTR_W]),
      .gene_type     (type_p1),
      .rand_msel     (msel_p1[i*ATTR_W +: ATTR_W]),
      .rand_mval     (mval_p1[i*ATTR_W +: ATTR_W]),
      .mutation_prob (prob_p1),
      .mut_val       (mut_val[i*ATTR_W +: ATTR_W]),
      .mut_flag      (mut_flag[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= accept;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 boundary: crossover result plus everything mutation needs
  always_ff @(posedge clk) begin
    if (accept) begin
      xo_p1   <= xo_val;
      type_p1 <= bus.gene_type;
      msel_p1 <= bus.rand_msel;
      mval_p1 <= bus.rand_mval;
      prob_p1 <= bus.mutation_prob;
    end
  end

  // Stage 2 boundary: output registers, frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      child_p2 <= '0;
      type_p2  <= 1'b0;
      flags_p2 <= '0;
    end else if (adv_p2 && vld_p1) begin
      child_p2 <= mut_val;
      type_p2  <= type_p1;
      flags_p2 <= mut_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         mut_count <= '0;
    else if (stat_clr) mut_count <= out_hs ? popcount(flags_p2) : '0;
    else if (out_hs)   mut_count <= sat_add(mut_count, popcount(flags_p2));
  end

  assign bus.out_valid  = vld_p2;
  assign bus.child      = child_p2;
  assign bus.child_type = type_p2;
  assign bus.mut_flags  = flags_p2;
endmodule

// File: tb/tb_gene_xover_mutate_pipe.sv
// Bench for gene_xover_mutate_pipe: directed beats plus random traffic scored
// against a per-attribute behavioural model; a CNT_W=4 twin exercises saturation.
module tb_gene_xover_mutate_pipe;
  typedef struct {
    logic [23:0] child;
    logic [2:0]  flags;
    logic        typ;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stat_clr;
  logic [15:0] mc16;
  logic [3:0]  mc4;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   cnt16, cnt4, emitted;
  logic stall_prev, last_acc, last_block;
  logic [23:0] held_child;
  logic [2:0]  held_flags;
  logic        held_type;

  always #5 clk = ~clk;

  gene_xover_mutate_pipe_if #(.ATTR_W(8), .NUM_ATTR(3)) if0 ();
  gene_xover_mutate_pipe_if #(.ATTR_W(8), .NUM_ATTR(3)) if1 ();

  assign if1.in_valid      = if0.in_valid;
  assign if1.gene_a        = if0.gene_a;
  assign if1.gene_b        = if0.gene_b;
  assign if1.gene_type     = if0.gene_type;
  assign if1.bias          = if0.bias;
  assign if1.rand_xover    = if0.rand_xover;
  assign if1.rand_msel     = if0.rand_msel;
  assign if1.rand_mval     = if0.rand_mval;
  assign if1.mutation_prob = if0.mutation_prob;
  assign if1.out_ready     = if0.out_ready;

  gene_xover_mutate_pipe dut16 (
    .clk(clk), .reset(reset), .bus(if0), .stat_clr(stat_clr), .mut_count(mc16)
  );

  gene_xover_mutate_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if1), .stat_clr(stat_clr), .mut_count(mc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Child gene computed straight from the crossover/mutation rules
  function automatic exp_t model(input logic [23:0] a, b, rx, ms, mv,
                                 input logic [7:0] prob, input logic typ, input logic bs);
    exp_t e;
    e.child = '0;
    e.flags = '0;
    e.typ   = typ;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] fitter, other, v, m;
      fitter = bs ? b[i*8 +: 8] : a[i*8 +: 8];
      other  = bs ? a[i*8 +: 8] : b[i*8 +: 8];
      v = (int'(rx[i*8 +: 8]) <= 64) ? fitter : other;
      if (typ) m = (i == 0) ? 8'h01 : 8'h00;
      else     m = (i == 0) ? 8'hFF : ((i == 1) ? 8'h0F : 8'h07);
      if (int'(ms[i*8 +: 8]) <= int'(prob)) begin
        v = mv[i*8 +: 8] & m;
        e.flags[i] = 1'b1;
      end
      e.child[i*8 +: 8] = v;
    end
    return e;
  endfunction

  task automatic set_beat(input logic typ, input logic bs, input logic [23:0] a, b, rx, ms, mv,
                          input logic [7:0] prob);
    if0.gene_type = typ;  if0.bias = bs;
    if0.gene_a = a;       if0.gene_b = b;
    if0.rand_xover = rx;  if0.rand_msel = ms;  if0.rand_mval = mv;
    if0.mutation_prob = prob;
  endtask

  task automatic rand_beat();
    logic [7:0] p;
    case ($urandom % 4)
      0:       p = 8'h00;
      1:       p = 8'hFF;
      default: p = 8'($urandom);
    endcase
    set_beat(1'($urandom), 1'($urandom), 24'($urandom), 24'($urandom),
             24'($urandom), 24'($urandom), 24'($urandom), p);
  endtask

  // One clock: sample at negedge+1, score, advance the model, then step to next negedge
  task automatic tick();
    exp_t e;
    int   pop;
    logic acc, ohs;
    #1;
    acc = ((if0.in_valid && if0.in_ready) === 1'b1);
    ohs = ((if0.out_valid && if0.out_ready) === 1'b1);
    last_acc   = acc;
    last_block = ((if0.in_valid && !if0.in_ready) === 1'b1);
    pop = 0;
    if (reset) begin
      chk("in_ready_during_reset", 32'(if0.in_ready), 32'd0);
      q.delete();
      cnt16 = 0;
      cnt4  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("mut_count_w16", 32'(mc16), cnt16);
      chk("mut_count_w4", 32'(mc4), cnt4);
      if (stall_prev) begin
        chk("hold_out_valid", 32'(if0.out_valid), 32'd1);
        chk("hold_child", 32'(if0.child), 32'(held_child));
        chk("hold_flags", 32'(if0.mut_flags), 32'(held_flags));
        chk("hold_type", 32'(if0.child_type), 32'(held_type));
      end
      if (ohs) begin
        if (q.size() == 0) begin
          chk("out_valid_nothing_pending", 32'(if0.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          emitted++;
          chk("child", 32'(if0.child), 32'(e.child));
          chk("mut_flags", 32'(if0.mut_flags), 32'(e.flags));
          chk("child_type", 32'(if0.child_type), 32'(e.typ));
          chk("child_w4dut", 32'(if1.child), 32'(e.child));
          chk("out_valid_w4dut", 32'(if1.out_valid), 32'd1);
          pop = $countones(e.flags);
        end
      end
      if (acc)
        q.push_back(model(if0.gene_a, if0.gene_b, if0.rand_xover, if0.rand_msel,
                          if0.rand_mval, if0.mutation_prob, if0.gene_type, if0.bias));
      if (stat_clr) begin
        cnt16 = ohs ? pop : 0;
        cnt4  = ohs ? sat(pop, 15) : 0;
      end else begin
        cnt16 = sat(cnt16 + pop, 65535);
        cnt4  = sat(cnt4 + pop, 15);
      end
      stall_prev = (if0.out_valid === 1'b1) && (if0.out_ready === 1'b0);
      held_child = if0.child;
      held_flags = if0.mut_flags;
      held_type  = if0.child_type;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [23:0] exp_child, input logic [2:0] exp_flags);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, 32'(last_acc), 32'd1);
    if0.in_valid = 1'b0;
    chk({tag, "_out_valid_after_1"}, 32'(if0.out_valid), 32'd0);
    tick();
    chk({tag, "_out_valid_after_2"}, 32'(if0.out_valid), 32'd1);
    chk({tag, "_child"}, 32'(if0.child), 32'(exp_child));
    chk({tag, "_flags"}, 32'(if0.mut_flags), 32'(exp_flags));
    tick();
  endtask

  initial begin
    int sent, t;
    logic saw_block;
    reset = 1'b1;
    stat_clr = 1'b0;
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    set_beat(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    cnt16 = 0; cnt4 = 0; emitted = 0;
    stall_prev = 1'b0; last_acc = 1'b0; last_block = 1'b0;
    held_child = '0; held_flags = '0; held_type = 1'b0;
    @(negedge clk);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_child", 32'(if0.child), 32'd0);
    chk("rst_child_type", 32'(if0.child_type), 32'd0);
    chk("rst_mut_flags", 32'(if0.mut_flags), 32'd0);
    chk("rst_mut_count", 32'(mc16), 32'd0);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clk);

    // Directed beats
    set_beat(1'b0, 1'b0, 24'h030510, 24'h070A20, 24'h404040, 24'hFFFFFF, 24'h5A5A5A, 8'h10);
    send_one("node_from_a", 24'h030510, 3'b000);
    set_beat(1'b0, 1'b0, 24'h030510, 24'h070A20, 24'h404041, 24'hFFFFFF, 24'h5A5A5A, 8'h10);
    send_one("xover_attr0_b", 24'h030520, 3'b000);
    set_beat(1'b1, 1'b0, 24'h030510, 24'h070A20, 24'h404040, 24'h123456, 24'hFFFFFF, 8'hFF);
    send_one("conn_all_mut", 24'h000001, 3'b111);
    chk("count_after_conn", 32'(mc16), 32'd3);
    set_beat(1'b0, 1'b0, 24'h030510, 24'h070A20, 24'h404040, 24'h00FF00, 24'hFFFFFF, 8'h00);
    send_one("node_prob0", 24'h0705FF, 3'b101);
    chk("count_after_prob0", 32'(mc16), 32'd5);

    // Saturation of the 4-bit twin
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b0, 1'b1, 24'h111111, 24'h222222, 24'h808080, 24'hFFFFFF, 24'hFFFFFF, 8'hFF);
      send_one("sat_beat", 24'h070FFF, 3'b111);
    end
    chk("count_w4_saturated", 32'(mc4), 32'd15);
    chk("count_w16_no_sat", 32'(mc16), 32'd17);

    // stat_clr coinciding with a two-flag handshake
    set_beat(1'b0, 1'b0, 24'h030510, 24'h070A20, 24'h404040, 24'h00FF00, 24'hFFFFFF, 8'h00);
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_with_hs_w16", 32'(mc16), 32'd2);
    chk("clr_with_hs_w4", 32'(mc4), 32'd2);

    // Backpressure: 4 beats with the consumer stalled for a few cycles
    emitted = 0; sent = 0; t = 0; saw_block = 1'b0;
    rand_beat();
    while ((sent < 4 || q.size() > 0) && t < 40) begin
      if0.in_valid  = (sent < 4);
      if0.out_ready = !(t >= 2 && t <= 5);
      tick();
      if (last_block) saw_block = 1'b1;
      if (last_acc) begin
        sent++;
        rand_beat();
      end
      t++;
    end
    chk("bp_no_timeout", 32'(t < 40), 32'd1);
    chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    chk("bp_all_emitted", 32'(emitted), 32'd4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_beat();
      if0.in_valid  = ($urandom % 4) != 0;
      if0.out_ready = ($urandom % 3) != 0;
      stat_clr      = ($urandom % 40) == 0;
      tick();
    end
    stat_clr = 1'b0;
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    emitted = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_model_empty", 32'(q.size()), 32'd0);

    // Reset with two beats in flight
    rand_beat();
    if0.in_valid = 1'b1;
    if0.out_ready = 1'b0;
    tick();
    chk("inflight_accept_1", 32'(last_acc), 32'd1);
    tick();
    chk("inflight_accept_2", 32'(last_acc), 32'd1);
    if0.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_flush_out_valid", 32'(if0.out_valid), 32'd0);
    if0.out_ready = 1'b1;
    emitted = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_flush_nothing_out", 32'(if0.out_valid), 32'd0);
    end
    chk("reset_flush_emitted", 32'(emitted), 32'd0);
    chk("reset_flush_count", 32'(mc16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
